fe_fetch_ctrl: RTL and testbench

Front-end fetch sequencer: owns the fetch PC register and chooses next PC in priority order reset > redirect > hold (no request accepted) > PC+2. Issues one instruction-memory request at a time over a valid/ready handshake and buffers returned instructions in a 2-entry queue toward decode. Sits between the back-end redirect source, instruction memory and the decode stage. Discards stale responses after a redirect.

---
 rtl/fe_fetch_ctrl_pkg.sv | 22 ++
 rtl/fe_fetch_queue.sv | 49 ++++
 rtl/fe_fetch_ctrl.sv | 97 +++++++++
 tb/tb_fe_fetch_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fe_fetch_ctrl_pkg.sv
// Shared types and constants for the front-end fetch sequencer.
// No logic; imported by fe_fetch_ctrl and fe_fetch_queue.
package fe_fetch_ctrl_pkg;

    localparam int WORD_SIZE_P       = 16;
    localparam int FETCH_QUEUE_DEPTH = 2;
    localparam int INSTR_BYTES       = 2;

    localparam logic [WORD_SIZE_P-1:0] RESET_PC_P = '0;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fe_fetch_state_e;

    typedef struct packed {
        logic [WORD_SIZE_P-1:0] instr;
        logic [WORD_SIZE_P-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fe_fetch_queue.sv
// Two-entry FIFO of {instr, pc} toward decode with push/pop/flush and occupancy count.
// Latency: push visible at head next cycle; backpressure: caller must not push when full unless popping.
module fe_fetch_queue
    import fe_fetch_ctrl_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_vld,
    input  fetch_entry_t push_dat,
    input  logic         pop_vld,
    input  logic         flush,
    output logic         head_vld,
    output fetch_entry_t head_dat,
    output logic [1:0]   count
);

    fetch_entry_t mem [FETCH_QUEUE_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign head_vld = (count != 2'd0);
    assign pop_ok   = pop_vld && head_vld;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_vld && ((count != 2'd2) || pop_ok);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fe_fetch_ctrl.sv
// Fetch PC owner: one outstanding imem request, stale-response drain after redirect, 2-deep decode queue.
// Latency: response at t -> decode valid and next request at t+1; backpressure: requests stop while queue holds 2.
module fe_fetch_ctrl
    import fe_fetch_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   redirect_v_i,
    input  logic [WORD_SIZE_P-1:0] redirect_pc_i,
    output logic                   imem_req_v_o,
    output logic [WORD_SIZE_P-1:0] imem_req_addr_o,
    input  logic                   imem_req_ready_i,
    input  logic                   imem_resp_v_i,
    input  logic [WORD_SIZE_P-1:0] imem_resp_data_i,
    output logic                   fd_v_o,
    output logic [WORD_SIZE_P-1:0] fd_instr_o,
    output logic [WORD_SIZE_P-1:0] fd_pc_o,
    input  logic                   fd_ready_i
);

    fe_fetch_state_e        state_q, state_d;
    logic [WORD_SIZE_P-1:0] pc_q, pc_d;
    logic [WORD_SIZE_P-1:0] tag_pc_q, tag_pc_d;
    logic                   req_fire;
    logic                   push_vld;
    logic                   flush;
    logic                   q_vld;
    logic [1:0]             q_count;
    fetch_entry_t           push_dat;
    fetch_entry_t           head_dat;

    // Reset gating keeps the request low while reset is held, since the reset state is REQ.
    assign imem_req_v_o    = !reset_i && (state_q == REQ) && !redirect_v_i && (q_count < 2'd2);
    assign imem_req_addr_o = pc_q;
    assign req_fire        = imem_req_v_o && imem_req_ready_i;

    assign fd_v_o     = q_vld && !redirect_v_i;
    assign fd_instr_o = head_dat.instr;
    assign fd_pc_o    = head_dat.pc;

    assign push_dat.instr = imem_resp_data_i;
    assign push_dat.pc    = tag_pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tag_pc_d = tag_pc_q;
        push_vld = 1'b0;
        flush    = 1'b0;
        if (redirect_v_i) begin
            pc_d  = redirect_pc_i & ~WORD_SIZE_P'(1);
            flush = 1'b1;
            // A response arriving with the redirect retires the outstanding request.
            if (state_q == REQ || imem_resp_v_i) state_d = REQ;
            else                                 state_d = DRAIN;
        end else begin
            case (state_q)
                REQ: if (req_fire) begin
                    tag_pc_d = pc_q;
                    pc_d     = pc_q + WORD_SIZE_P'(INSTR_BYTES);
                    state_d  = WAIT;
                end
                WAIT: if (imem_resp_v_i) begin
                    push_vld = 1'b1;
                    state_d  = REQ;
                end
                DRAIN: if (imem_resp_v_i) state_d = REQ;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC_P;
            tag_pc_q <= RESET_PC_P;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tag_pc_q <= tag_pc_d;
        end
    end

    fe_fetch_queue u_queue (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (fd_v_o && fd_ready_i),
        .flush    (flush),
        .head_vld (q_vld),
        .head_dat (head_dat),
        .count    (q_count)
    );

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed bench for fe_fetch_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_fe_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        redirect_v_i;
    logic [15:0] redirect_pc_i;
    logic        imem_req_v_o;
    logic [15:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_v_i;
    logic [15:0] imem_resp_data_i;
    logic        fd_v_o;
    logic [15:0] fd_instr_o;
    logic [15:0] fd_pc_o;
    logic        fd_ready_i;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    fe_fetch_ctrl dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_v_o     (imem_req_v_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_resp_v_i    (imem_resp_v_i),
        .imem_resp_data_i (imem_resp_data_i),
        .fd_v_o           (fd_v_o),
        .fd_instr_o       (fd_instr_o),
        .fd_pc_o          (fd_pc_o),
        .fd_ready_i       (fd_ready_i)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to next falling edge, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic rst, input logic rdy, input logic resp, input logic [15:0] data,
                       input logic redir, input logic [15:0] rpc, input logic fdr);
        @(negedge clk_i);
        reset_i          = rst;
        imem_req_ready_i = rdy;
        imem_resp_v_i    = resp;
        imem_resp_data_i = data;
        redirect_v_i     = redir;
        redirect_pc_i    = rpc;
        fd_ready_i       = fdr;
        #1;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [15:0] addr);
        chk({tag, "_req_v"}, {15'd0, imem_req_v_o}, {15'd0, v});
        chk({tag, "_addr"}, imem_req_addr_o, addr);
    endtask

    task automatic chk_fd(input string tag, input logic v, input logic [15:0] instr, input logic [15:0] pc);
        chk({tag, "_fd_v"}, {15'd0, fd_v_o}, {15'd0, v});
        if (v) begin
            chk({tag, "_fd_instr"}, fd_instr_o, instr);
            chk({tag, "_fd_pc"}, fd_pc_o, pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; redirect_v_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
        imem_resp_v_i = 1'b0; imem_resp_data_i = '0; fd_ready_i = 1'b0;
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 0);
        cyc(1, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("rst", 0, 16'h0000);
        chk("rst_fd_v", {15'd0, fd_v_o}, 16'd0);
        chk("rst_fd_instr", fd_instr_o, 16'h0000);
        chk("rst_fd_pc", fd_pc_o, 16'h0000);

        // Stream two instructions with decode stalled
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("first", 1, 16'h0000);
        cyc(0, 1, 1, 16'h1111, 0, 16'h0, 0);
        chk_req("wait0", 0, 16'h0002);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_fd("resp0", 1, 16'h1111, 16'h0000);
        chk_req("second", 1, 16'h0002);
        cyc(0, 1, 1, 16'h2222, 0, 16'h0, 0);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("full", 0, 16'h0004);
        chk_fd("full_head", 1, 16'h1111, 16'h0000);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 1);
        chk_req("full_hold", 0, 16'h0004);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_fd("pop1", 1, 16'h2222, 16'h0002);
        chk_req("after_pop", 1, 16'h0004);

        // Redirect while waiting: response drained, target fetched
        cyc(0, 1, 0, 16'h0, 1, 16'h0041, 0);
        chk_req("redir_wait", 0, 16'h0006);
        chk("redir_wait_fd_v", {15'd0, fd_v_o}, 16'd0);
        cyc(0, 1, 1, 16'hDEAD, 0, 16'h0, 0);
        chk_req("drain", 0, 16'h0040);
        chk("drain_fd_v", {15'd0, fd_v_o}, 16'd0);

        // Memory not ready for 3 cycles: address holds
        cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);
        chk("drain_drop_fd_v", {15'd0, fd_v_o}, 16'd0);
        chk_req("stall1", 1, 16'h0040);
        cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);
        chk_req("stall2", 1, 16'h0040);
        cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);
        chk_req("stall3", 1, 16'h0040);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("stall_go", 1, 16'h0040);

        // Redirect coincident with response
        cyc(0, 1, 1, 16'hBEEF, 1, 16'h0100, 0);
        chk_req("redir_resp", 0, 16'h0042);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("redir_resp_next", 1, 16'h0100);
        chk("redir_resp_fd_v", {15'd0, fd_v_o}, 16'd0);
        cyc(0, 1, 1, 16'h3333, 0, 16'h0, 0);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_fd("tgt0", 1, 16'h3333, 16'h0100);
        chk_req("tgt1", 1, 16'h0102);
        cyc(0, 1, 1, 16'h4444, 0, 16'h0, 0);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("full2", 0, 16'h0104);
        chk_fd("full2_head", 1, 16'h3333, 16'h0100);

        // Redirect with full queue flushes both entries
        cyc(0, 1, 0, 16'h0, 1, 16'hFFFF, 1);
        chk("flush_fd_v", {15'd0, fd_v_o}, 16'd0);
        chk_req("flush", 0, 16'h0104);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk("flushed_fd_v", {15'd0, fd_v_o}, 16'd0);
        chk_req("wrap_req", 1, 16'hFFFE);
        cyc(0, 1, 1, 16'h5555, 0, 16'h0, 0);
        chk_req("wrap_wait", 0, 16'h0000);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_fd("wrap_head", 1, 16'h5555, 16'hFFFE);
        chk_req("wrap_next", 1, 16'h0000);

        // Reset asserted while waiting
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("wait_pre_rst", 0, 16'h0002);
        cyc(1, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("midrst", 0, 16'h0000);
        chk("midrst_fd_v", {15'd0, fd_v_o}, 16'd0);
        chk("midrst_fd_instr", fd_instr_o, 16'h0000);
        chk("midrst_fd_pc", fd_pc_o, 16'h0000);
        cyc(0, 1, 0, 16'h0, 0, 16'h0, 0);
        chk_req("rerelease", 1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
